// File: rtl/prog_clock_divider.sv
// Programmable clock divider: q has a period of D clk cycles and is high for ceil(D/2) of them.
// A new ratio is loaded through a one-deep shadow register. Define PROG_CLKDIV_TICK_EN to add the tick output.
module prog_clock_divider #(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 4
) (
    input  logic             clk,
    input  logic             ar,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             load_req,
    output logic             busy,
    output logic             load_ack,
    output logic             q
`ifdef PROG_CLKDIV_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [WIDTH-1:0] RST_D = WIDTH'(RESET_DIV);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] r_cnt;
    logic             r_pending;
    logic             r_q;
    logic             r_ack;

    logic [WIDTH:0]   w_half;
    logic             w_last;
    logic             w_commit;
    logic             w_capture;
    logic [WIDTH-1:0] w_din_legal;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0] w_shadow_next;
    logic             w_pending_next;
    logic             w_q_next;

    // The extra bit keeps ceil(D/2) correct for the largest ratio.
    assign w_half      = ({1'b0, r_div} + (WIDTH+1)'(1)) >> 1;
    assign w_last      = (r_cnt == r_div - WIDTH'(1));
    assign w_din_legal = (div_in < WIDTH'(2)) ? WIDTH'(2) : div_in;

    // A pending ratio commits only at a period boundary or on a stopped edge, so the period in progress is never altered.
    assign w_commit  = r_pending & (~en | w_last);
    assign w_capture = load_req & ~r_pending;

    always_comb begin
        w_cnt_next     = r_cnt + WIDTH'(1);
        w_q_next       = en & ({1'b0, r_cnt} < w_half);
        w_div_next     = r_div;
        w_shadow_next  = r_shadow;
        w_pending_next = r_pending;
        if (!en || w_last) begin
            w_cnt_next = '0;
        end
        if (w_commit) begin
            w_div_next     = r_shadow;
            w_pending_next = 1'b0;
        end else if (w_capture) begin
            w_shadow_next  = w_din_legal;
            w_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_div     <= RST_D;
            r_shadow  <= RST_D;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_q       <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_div     <= w_div_next;
            r_shadow  <= w_shadow_next;
            r_cnt     <= w_cnt_next;
            r_pending <= w_pending_next;
            r_q       <= w_q_next;
            r_ack     <= w_commit;
        end
    end

`ifdef PROG_CLKDIV_TICK_EN
    logic r_tick;

    // Fires on the edge that starts each period, i.e. together with every rising edge of q.
    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= en & (r_cnt == '0);
        end
    end

    assign tick = r_tick;
`endif

    assign busy     = r_pending;
    assign load_ack = r_ack;
    assign q        = r_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: each stimulus cycle queues its expected q/busy/load_ack,
// and a monitor pops and compares one entry per clock.
module tb_prog_clock_divider;

    logic        clk = 1'b0;
    logic        ar = 1'b1;
    logic        en = 1'b0;
    logic [15:0] div_in = '0;
    logic        load_req = 1'b0;
    logic        busy;
    logic        load_ack;
    logic        q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  q;
        logic  busy;
        logic  ack;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    always #5 clk = ~clk;

`ifdef PROG_CLKDIV_TICK_EN
    logic tick;
    logic q_prev = 1'b0;
    int   tick_cnt = 0;
    int   rise_cnt = 0;

    prog_clock_divider #(.WIDTH(16), .RESET_DIV(4)) dut (
        .clk(clk), .ar(ar), .en(en), .div_in(div_in), .load_req(load_req),
        .busy(busy), .load_ack(load_ack), .q(q), .tick(tick)
    );
`else
    prog_clock_divider #(.WIDTH(16), .RESET_DIV(4)) dut (
        .clk(clk), .ar(ar), .en(en), .div_in(div_in), .load_req(load_req),
        .busy(busy), .load_ack(load_ack), .q(q)
    );
`endif

    function automatic void chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: q/busy/ack got %b expected %b", name, got, exp);
        end
    endfunction

    // Monitor: one expected entry per clock edge that had stimulus queued.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk(cur.tag, {q, busy, load_ack}, {cur.q, cur.busy, cur.ack});
        end
`ifdef PROG_CLKDIV_TICK_EN
        if (tick) tick_cnt++;
        if (q && !q_prev) rise_cnt++;
        q_prev = q;
`endif
    end

    task automatic step(input logic e, input logic ld, input logic [15:0] d,
                        input logic eq, input logic eb, input logic ea, input string tag);
        @(negedge clk);
        en       = e;
        load_req = ld;
        div_in   = d;
        sb.push_back('{eq, eb, ea, tag});
    endtask

    // Run with en=1 and no loads; pat lists the expected q after each edge.
    task automatic run(input string pat, input logic eb, input string tag);
        for (int i = 0; i < pat.len(); i++) begin
            step(1'b1, 1'b0, 16'd0, pat[i] == "1", eb, 1'b0, $sformatf("%s[%0d]", tag, i));
        end
    endtask

    initial begin
        #1;
        chk("reset_state", {q, busy, load_ack}, 3'b000);
        repeat (2) @(negedge clk);
        ar = 1'b0;

        // Default ratio 4
        run("11001100", 1'b0, "d4");

        // Load 5 at cnt=1; a second request (9) while busy is ignored
        step(1, 0, 16'd0, 1, 0, 0, "pre_load");
        step(1, 1, 16'd5, 1, 1, 0, "load5");
        step(1, 1, 16'd9, 0, 1, 0, "load9_ignored");
        step(1, 0, 16'd0, 0, 0, 1, "ack5");
        run("1110011100", 1'b0, "d5");

        // div_in=0 becomes ratio 2
        step(1, 1, 16'd0, 1, 1, 0, "load0");
        run("110", 1'b1, "d5_tail");
        step(1, 0, 16'd0, 0, 0, 1, "ack2");
        run("101010", 1'b0, "d2");

        // Maximum ratio 65535; a load of 3 issued on its first edge waits for the full period
        step(1, 1, 16'hFFFF, 1, 1, 0, "load_max");
        step(1, 0, 16'd0, 0, 0, 1, "ack_max");
        step(1, 1, 16'd3, 1, 1, 0, "max[0]_load3");
        for (int i = 1; i < 65534; i++) begin
            step(1, 0, 16'd0, i < 32768, 1, 0, $sformatf("max[%0d]", i));
        end
        step(1, 0, 16'd0, 0, 0, 1, "max_boundary_ack3");
        run("110110", 1'b0, "d3");

        // Stop with a load pending: commit on the stopped edge, restart high with the new ratio
        step(1, 0, 16'd0, 1, 0, 0, "d3_c0");
        step(1, 1, 16'd7, 1, 1, 0, "load7");
        step(0, 0, 16'd0, 0, 0, 1, "stop_ack7");
        step(0, 0, 16'd0, 0, 0, 0, "stopped");
        run("11110001", 1'b0, "d7");

        // Load while stopped (div_in=1 -> 2) commits on the next stopped edge
        step(0, 1, 16'd1, 0, 1, 0, "stop_load1");
        step(0, 0, 16'd0, 0, 0, 1, "stop_ack2");
        run("1010", 1'b0, "d2b");

        // Asynchronous reset with a load pending
        step(1, 1, 16'd5, 1, 1, 0, "load5_pre_reset");
        @(negedge clk);
        en = 1'b0;
        load_req = 1'b0;
        #2;
        ar = 1'b1;
        #1;
        chk("async_reset", {q, busy, load_ack}, 3'b000);
        repeat (2) @(negedge clk);
        ar = 1'b0;
        run("11001100", 1'b0, "post_reset_d4");

        @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
`ifdef PROG_CLKDIV_TICK_EN
        checks++;
        if (tick_cnt != rise_cnt || tick_cnt == 0) begin
            errors++;
            $display("FAIL tick_count: got %0d ticks, expected %0d (q rising edges)", tick_cnt, rise_cnt);
        end
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
